inst_sequencer_rom: RTL

//  Instruction-issue front end for processor_8_16bit: replaces SW/KEY manual entry.

---
 rtl/inst_seq_pkg.sv | 16 +
 rtl/inst_sequencer_rom.sv | 68 ++++++
 2 files changed

// File: rtl/inst_seq_pkg.sv
// inst_seq_pkg: shared widths, halt encoding and sequencer state set
package inst_seq_pkg;
  localparam int INST_W = 10;
  localparam int DATA_W = 8;
  localparam logic [INST_W-1:0] HALT_WORD = 10'h3FF;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    ROMWAIT   = 3'd2,
    ISSUE     = 3'd3,
    WAIT_DONE = 3'd4,
    PAUSE     = 3'd5,
    HALT      = 3'd6,
    ERROR     = 3'd7
  } state_t;
endpackage

// File: rtl/inst_sequencer_rom.sv
// inst_sequencer_rom: fetches instructions from a sync ROM and issues them to processor_8_16bit
module inst_sequencer_rom
  import inst_seq_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Step_mode,
  input  logic              Step,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_q,
  output logic [INST_W-1:0] Func,
  output logic [DATA_W-1:0] Data,
  output logic              w,
  input  logic              Done,
  output logic [ADDR_W-1:0] PC,
  output logic              Busy,
  output logic              Halted,
  output logic              Error
);
  state_t            state;
  logic [INST_W-1:0] inst;
  logic [7:0]        timer;
  assign rom_addr = PC;
  assign Busy     = !(state inside {IDLE, HALT, ERROR});
  assign Halted   = state == HALT;
  assign Error    = state == ERROR;
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      PC    <= '0;
      inst  <= '0;
      Func  <= '0;
      Data  <= '0;
      w     <= 1'b0;
      timer <= '0;
    end else begin
      w <= 1'b0;
      case (state)
        IDLE:    state <= Start ? FETCH : IDLE;
        FETCH:   state <= ROMWAIT;
        ROMWAIT: begin
          inst  <= rom_q;
          state <= rom_q == HALT_WORD ? HALT : ISSUE;
        end
        // a stale Done from the previous instruction must fall before the next issue
        ISSUE: begin
          Func  <= inst;
          Data  <= inst[DATA_W-1:0];
          w     <= !Done;
          timer <= '0;
          state <= Done ? ISSUE : WAIT_DONE;
        end
        WAIT_DONE:
          if (Done) begin
            PC    <= PC == '1 ? PC : PC + 1'b1;
            state <= PC == '1 ? HALT : Step_mode ? PAUSE : FETCH;
          end else if (timer == 8'(TIMEOUT)) state <= ERROR;
          else timer <= timer + 1'b1;
        PAUSE:   state <= Step || !Step_mode ? FETCH : PAUSE;
        default: ;
      endcase
    end
  end
endmodule
